// File: rtl/led_display_package.sv
// Shared types and constants for the LED panel scan path.
package led_display_package;

  localparam int GL_NUM_COLS  = 64;
  localparam int GL_NUM_ROWS  = 32;
  localparam int GL_ROW_PAIRS = GL_NUM_ROWS / 2;

  // One half-panel worth of colour planes; red sits in the low bits.
  typedef struct packed {
    logic [GL_NUM_COLS-1:0] blue;
    logic [GL_NUM_COLS-1:0] green;
    logic [GL_NUM_COLS-1:0] red;
  } rgb_plane_t;

  // One row-pair: the row in the top half and its partner in the bottom half.
  typedef struct packed {
    rgb_plane_t top;
    rgb_plane_t bot;
  } rgb_row_t;

  localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_WAIT_ON,
    ST_BLANK_PRE,
    ST_LATCH,
    ST_BLANK_POST
  } scan_state_t;

endpackage

// File: rtl/led_row_shifter.sv
// Serialises one row-pair onto the panel data pins: six colour planes,
// column MSB first, one bclk pulse per column (low phase then high phase).
module led_row_shifter #(
  parameter int NUM_COLS = 64
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  i_load,
  input  logic [3*NUM_COLS-1:0] i_top_planes,  // {blue, green, red}
  input  logic [3*NUM_COLS-1:0] i_bot_planes,  // {blue, green, red}
  output logic                  o_done,
  output logic                  o_bclk,
  output logic [2:0]            o_rgb_top,
  output logic [2:0]            o_rgb_bot
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  logic             r_active;
  logic             r_phase;    // 0: low half of the bclk period, 1: high half
  logic             r_bclk;
  logic [COL_W-1:0] r_col_cnt;
  logic             w_last_col;
  logic             w_advance;

  assign w_last_col = (r_col_cnt == LAST_COL);
  // Data moves to the next column only as bclk falls, so it is frozen while bclk is high.
  assign w_advance  = r_active & r_phase & ~w_last_col;
  assign o_done     = r_active & r_phase & w_last_col;
  assign o_bclk     = r_bclk;

  // Phase toggle, column counter and the bclk pin itself.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_active  <= 1'b0;
      r_phase   <= 1'b0;
      r_bclk    <= 1'b0;
      r_col_cnt <= '0;
    end else if (i_load) begin
      r_active  <= 1'b1;
      r_phase   <= 1'b0;
      r_bclk    <= 1'b0;
      r_col_cnt <= '0;
    end else if (r_active) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
        r_bclk  <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_bclk  <= 1'b0;
        if (w_last_col) begin
          r_active <= 1'b0;
        end else begin
          r_col_cnt <= r_col_cnt + COL_W'(1);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_plane
      logic [NUM_COLS-1:0] w_top_load;
      logic [NUM_COLS-1:0] w_bot_load;
      logic [NUM_COLS-1:0] r_top_sr;
      logic [NUM_COLS-1:0] r_bot_sr;
      logic                r_top_bit;
      logic                r_bot_bit;

      assign w_top_load = i_top_planes[gi*NUM_COLS +: NUM_COLS];
      assign w_bot_load = i_bot_planes[gi*NUM_COLS +: NUM_COLS];

      // Present the MSB on load, then pop one column per bclk period.
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          r_top_sr  <= '0;
          r_bot_sr  <= '0;
          r_top_bit <= 1'b0;
          r_bot_bit <= 1'b0;
        end else if (i_load) begin
          r_top_sr  <= w_top_load << 1;
          r_bot_sr  <= w_bot_load << 1;
          r_top_bit <= w_top_load[NUM_COLS-1];
          r_bot_bit <= w_bot_load[NUM_COLS-1];
        end else if (w_advance) begin
          r_top_sr  <= r_top_sr << 1;
          r_bot_sr  <= r_bot_sr << 1;
          r_top_bit <= r_top_sr[NUM_COLS-1];
          r_bot_bit <= r_bot_sr[NUM_COLS-1];
        end
      end

      assign o_rgb_top[gi] = r_top_bit;
      assign o_rgb_bot[gi] = r_bot_bit;
    end
  endgenerate

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75 scan sequencer: fetch a row-pair, shift it while the previous row is
// lit, blank, latch, advance the address, repeat.
module led_scan_ctrl
  import led_display_package::*;
#(
  parameter int NUM_COLS     = GL_NUM_COLS,
  parameter int NUM_ROWS     = GL_NUM_ROWS,
  parameter int ADDR_W       = 4,
  parameter int ON_CYCLES    = 256,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    enable,
  output logic [ADDR_W-1:0]       row_req_addr,
  output logic                    row_ready,
  input  logic                    row_valid,
  input  logic [GL_RGB_ROW_W-1:0] row_data,
  output logic                    bclk,
  output logic [2:0]              rgb_top,
  output logic [2:0]              rgb_bot,
  output logic [ADDR_W-1:0]       addr,
  output logic                    oe,
  output logic                    le,
  output logic                    frame_start,
  output logic                    busy
);

  localparam int ON_W = $clog2(ON_CYCLES + 1);
  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [ON_W-1:0]   ON_MAX    = ON_W'(ON_CYCLES);
  localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(BLANK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROWS / 2 - 1);

  scan_state_t       r_state, w_state_next;
  logic              r_oe, w_oe_next;
  logic              r_le, w_le_next;
  logic              r_frame_start, w_frame_start_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [ADDR_W-1:0] r_next_addr, w_next_addr_next;
  logic [ON_W-1:0]   r_on_cnt, w_on_cnt_next;
  logic [BL_W-1:0]   r_blank_cnt, w_blank_cnt_next;
  logic              w_on_expired;
  logic              w_load;
  logic              w_shift_done;
  rgb_row_t          w_row;

  assign w_row        = row_data;
  assign w_on_expired = (r_on_cnt >= ON_MAX);

  // The handshake is suppressed once a stop is requested, so a draining FETCH never takes data.
  assign row_ready    = (r_state == ST_FETCH) && enable;
  assign row_req_addr = r_next_addr;
  assign busy         = (r_state != ST_IDLE);
  assign oe           = r_oe;
  assign le           = r_le;
  assign addr         = r_addr;
  assign frame_start  = r_frame_start;

  led_row_shifter #(
    .NUM_COLS(NUM_COLS)
  ) u_shifter (
    .clk         (clk),
    .n_reset     (n_reset),
    .i_load      (w_load),
    .i_top_planes(w_row.top),
    .i_bot_planes(w_row.bot),
    .o_done      (w_shift_done),
    .o_bclk      (bclk),
    .o_rgb_top   (rgb_top),
    .o_rgb_bot   (rgb_bot)
  );

  // Next-state and next-output decode; panel control pins are registered.
  always_comb begin
    w_state_next       = r_state;
    w_oe_next          = r_oe;
    w_le_next          = 1'b0;
    w_frame_start_next = 1'b0;
    w_addr_next        = r_addr;
    w_next_addr_next   = r_next_addr;
    w_blank_cnt_next   = r_blank_cnt;
    w_load             = 1'b0;
    // Lit time accumulates in every state while the panel is on.
    w_on_cnt_next      = (!r_oe && !w_on_expired) ? r_on_cnt + ON_W'(1) : r_on_cnt;

    unique case (r_state)
      ST_IDLE: begin
        w_oe_next = 1'b1;
        if (enable) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (!enable) begin
          // Let the current row finish its full brightness slot before going dark.
          if (w_on_expired) begin
            w_oe_next    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else if (row_valid) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_shift_done) w_state_next = ST_WAIT_ON;
      end
      ST_WAIT_ON: begin
        if (w_on_expired) begin
          w_oe_next        = 1'b1;
          w_blank_cnt_next = '0;
          w_state_next     = ST_BLANK_PRE;
        end
      end
      ST_BLANK_PRE: begin
        if (r_blank_cnt == BL_LAST) begin
          w_le_next          = 1'b1;
          w_addr_next        = r_next_addr;
          w_frame_start_next = (r_next_addr == '0);
          w_state_next       = ST_LATCH;
        end else begin
          w_blank_cnt_next = r_blank_cnt + BL_W'(1);
        end
      end
      ST_LATCH: begin
        w_next_addr_next = (r_next_addr == LAST_ADDR) ? '0 : r_next_addr + ADDR_W'(1);
        w_blank_cnt_next = '0;
        w_state_next     = ST_BLANK_POST;
      end
      ST_BLANK_POST: begin
        if (r_blank_cnt == BL_LAST) begin
          w_oe_next     = 1'b0;
          w_on_cnt_next = '0;
          w_state_next  = ST_FETCH;
        end else begin
          w_blank_cnt_next = r_blank_cnt + BL_W'(1);
        end
      end
      default: begin
        w_oe_next    = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered panel controls.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= ST_IDLE;
      r_oe          <= 1'b1;
      r_le          <= 1'b0;
      r_frame_start <= 1'b0;
      r_addr        <= '0;
      r_next_addr   <= '0;
      r_on_cnt      <= ON_MAX;
      r_blank_cnt   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_oe          <= w_oe_next;
      r_le          <= w_le_next;
      r_frame_start <= w_frame_start_next;
      r_addr        <= w_addr_next;
      r_next_addr   <= w_next_addr_next;
      r_on_cnt      <= w_on_cnt_next;
      r_blank_cnt   <= w_blank_cnt_next;
    end
  end

endmodule
